ms_boot_seq: RTL

//  Table-driven, parametrised start-up sequencer; next generation of the fixed loader/CPU start FSM.

---
 rtl/ms_boot_seq.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/ms_boot_seq.sv
// Table-driven start-up sequencer: walks a command table after reset and issues
// each entry as one DBIO transaction, waiting for ack / loader idle with timeout.
module ms_boot_seq #(
    parameter int CCmdCnt  = 8,
    parameter int CAddrLen = 12,
    parameter int CDataLen = 64,
    parameter int CTimeout = 255
) (
    input  logic                           AClkH,
    input  logic                           AResetH,
    input  logic                           AClkHEn,
    input  logic                           ALoadFW,
    input  logic                           ALdrActive,
    input  logic                           ARestart,
    output logic [3:0]                     ATblIdx,
    input  logic [CAddrLen+CDataLen+12:0]  ATblEntry,
    output logic [CAddrLen-1:0]            ADbioAddr,
    output logic [CDataLen-1:0]            ADbioMosi,
    output logic [3:0]                     ADbioMosiIdx,
    output logic [3:0]                     ADbioMisoIdx,
    output logic                           ADbioMosi1st,
    output logic                           ADbioMiso1st,
    input  logic                           ADbioAck,
    output logic                           AReady,
    output logic                           AError,
    output logic [3:0]                     AErrIdx,
    output logic [7:0]                     ATest
);

    localparam int CEntW = CAddrLen + CDataLen + 13;
    // CondFW is only needed while fetching, so the entry register drops it
    localparam int CRegW = CEntW - 1;
    localparam logic [3:0]  CLastIdx = 4'(CCmdCnt - 1);
    localparam logic [15:0] CTmoLast = 16'(CTimeout - 1);
    localparam bit          CTmoOn   = (CTimeout != 0);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_FETCH    = 3'd1,
        S_ISSUE    = 3'd2,
        S_WAIT_ACK = 3'd3,
        S_WAIT_LDR = 3'd4,
        S_NEXT     = 3'd5,
        S_READY    = 3'd6,
        S_ERROR    = 3'd7
    } state_t;

    state_t             state_q, state_d;
    logic [3:0]         idx_q, idx_d;
    logic [15:0]        timer_q, timer_d;
    logic               fw_q, fw_d;
    logic [CRegW-1:0]   entry_q, entry_d;

    logic tbl_cond, tbl_last, ent_last, ent_wait_ldr, tmo_hit, issue;

    assign tbl_cond     = ATblEntry[2];
    assign tbl_last     = ATblEntry[0];
    assign ent_last     = entry_q[0];
    assign ent_wait_ldr = entry_q[1];
    assign tmo_hit      = CTmoOn && (timer_q == CTmoLast);

    always_ff @(posedge AClkH) begin
        if (AResetH) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            timer_q <= '0;
            fw_q    <= 1'b0;
            entry_q <= '0;
        end else if (AClkHEn) begin
            state_q <= state_d;
            idx_q   <= idx_d;
            timer_q <= timer_d;
            fw_q    <= fw_d;
            entry_q <= entry_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        timer_d = timer_q;
        fw_d    = fw_q;
        entry_d = entry_q;
        case (state_q)
            S_IDLE: begin
                fw_d    = ALoadFW;
                idx_d   = '0;
                state_d = S_FETCH;
            end
            S_FETCH: begin
                entry_d = {ATblEntry[CEntW-1:3], ATblEntry[1:0]};
                if (tbl_cond && !fw_q) begin
                    if (tbl_last || idx_q == CLastIdx) state_d = S_READY;
                    else                               idx_d   = idx_q + 4'd1;
                end else begin
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                timer_d = '0;
                if (ADbioAck) state_d = ent_wait_ldr ? S_WAIT_LDR : S_NEXT;
                else          state_d = S_WAIT_ACK;
            end
            S_WAIT_ACK: begin
                if (ADbioAck) begin
                    timer_d = '0;
                    state_d = ent_wait_ldr ? S_WAIT_LDR : S_NEXT;
                end else if (tmo_hit) begin
                    state_d = S_ERROR;
                end else begin
                    timer_d = timer_q + 16'd1;
                end
            end
            S_WAIT_LDR: begin
                if (!ALdrActive)  state_d = S_NEXT;
                else if (tmo_hit) state_d = S_ERROR;
                else              timer_d = timer_q + 16'd1;
            end
            S_NEXT: begin
                if (ent_last || idx_q == CLastIdx) begin
                    state_d = S_READY;
                end else begin
                    idx_d   = idx_q + 4'd1;
                    state_d = S_FETCH;
                end
            end
            S_READY: if (ARestart) state_d = S_IDLE;
            S_ERROR: if (ARestart) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign issue        = (state_q == S_ISSUE);
    assign ADbioAddr    = issue ? entry_q[CRegW-1 -: CAddrLen] : '0;
    assign ADbioMosi    = issue ? entry_q[12 +: CDataLen] : '0;
    assign ADbioMosiIdx = issue ? entry_q[11:8] : '0;
    assign ADbioMisoIdx = issue ? entry_q[7:4] : '0;
    assign ADbioMosi1st = issue & entry_q[3];
    assign ADbioMiso1st = issue & entry_q[2];

    assign ATblIdx = idx_q;
    assign AReady  = (state_q == S_READY);
    assign AError  = (state_q == S_ERROR);
    assign AErrIdx = AError ? idx_q : '0;
    assign ATest   = {fw_q, state_q, idx_q};

endmodule
